// File: rtl/ascii_num_parser.sv
// ascii_num_parser
//   Tokenises an ASCII byte stream from the UART receiver into integer
//   records for the puzzle solver cores. Each record holds the number value,
//   an end-of-line flag, an empty-line flag and an overflow flag.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   in_valid   one-cycle strobe: in_data holds a received byte
//   in_data    received byte (ASCII)
//   in_break   one-cycle strobe: BREAK received, aborts the current token
//   out_valid  record available
//   out_ready  consumer accepts the record when out_valid && out_ready
//   out_value  parsed value (two's complement when SIGNED), 0 for empty records
//   out_eol    record terminated by LF
//   out_empty  line end with no number in progress
//   out_ovf    magnitude exceeded 2^WIDTH-1 during accumulation
//   overrun    sticky: a record was dropped because the output register was full
module ascii_num_parser #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_break,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_eol,
  output logic             out_empty,
  output logic             out_ovf,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SIGN,
    NUM
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic             neg, neg_n;
  logic             ovf, ovf_n;

  logic             emit;
  logic [WIDTH-1:0] emit_value;
  logic             emit_eol;
  logic             emit_empty;
  logic             emit_ovf;

  logic             is_digit;
  logic             is_minus;
  logic             is_lf;
  logic             is_cr;
  logic [3:0]       digit_val;
  logic [WIDTH+3:0] mac;
  logic [WIDTH-1:0] signed_acc;
  logic             load;

  assign is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_minus  = (in_data == 8'h2D);
  assign is_lf     = (in_data == 8'h0A);
  assign is_cr     = (in_data == 8'h0D);
  // ASCII digits 0x30..0x39 carry their value in the low nibble
  assign digit_val = in_data[3:0];

  // acc*10 + d in WIDTH+4 bits; anything above bit WIDTH-1 is overflow
  assign mac = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
             + {{WIDTH{1'b0}}, digit_val};

  assign signed_acc = neg ? (~acc + 1'b1) : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      neg   <= neg_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    neg_n      = neg;
    ovf_n      = ovf;
    emit       = 1'b0;
    emit_value = '0;
    emit_eol   = 1'b0;
    emit_empty = 1'b0;
    emit_ovf   = 1'b0;

    if (in_break) begin
      state_n = IDLE;
      acc_n   = '0;
      neg_n   = 1'b0;
      ovf_n   = 1'b0;
    end else if (in_valid && !is_cr) begin
      case (state)
        NUM: begin
          if (is_digit) begin
            acc_n = mac[WIDTH-1:0];
            ovf_n = ovf | (|mac[WIDTH+3:WIDTH]);
          end else begin
            emit       = 1'b1;
            emit_value = signed_acc;
            emit_eol   = is_lf;
            emit_ovf   = ovf;
            acc_n      = '0;
            ovf_n      = 1'b0;
            if (is_minus && SIGNED) begin
              neg_n   = 1'b1;
              state_n = SIGN;
            end else begin
              neg_n   = 1'b0;
              state_n = IDLE;
            end
          end
        end
        default: begin
          // IDLE and SIGN share handling: a pending '-' survives only into
          // a digit; any other byte drops it and is treated as in IDLE.
          if (is_digit) begin
            acc_n   = WIDTH'(digit_val);
            ovf_n   = 1'b0;
            state_n = NUM;
          end else if (is_minus && SIGNED) begin
            neg_n   = 1'b1;
            state_n = SIGN;
          end else begin
            neg_n   = 1'b0;
            state_n = IDLE;
            if (is_lf) begin
              emit       = 1'b1;
              emit_eol   = 1'b1;
              emit_empty = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign load = emit && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_eol   <= 1'b0;
      out_empty <= 1'b0;
      out_ovf   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_value <= emit_value;
        out_eol   <= emit_eol;
        out_empty <= emit_empty;
        out_ovf   <= emit_ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (emit && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ascii_num_parser.sv
module tb_ascii_num_parser;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_break;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_eol;
  logic             out_empty;
  logic             out_ovf;
  logic             overrun;

  ascii_num_parser #(.WIDTH(WIDTH), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_break  (in_break),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_eol   (out_eol),
    .out_empty (out_empty),
    .out_ovf   (out_ovf),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic        eol;
    logic        empty;
    logic        ovf;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   ready_rand = 1'b0;

  // Reference model: token-level view of the stream.
  bit              m_in_num;
  bit              m_neg;
  bit              m_ovf;
  longint unsigned m_mag;

  function automatic void m_push(logic [31:0] v, bit eol, bit empty, bit ovf);
    rec_t r;
    r.value = v; r.eol = eol; r.empty = empty; r.ovf = ovf;
    exp_q.push_back(r);
  endfunction

  function automatic void m_clear();
    m_in_num = 1'b0; m_neg = 1'b0; m_ovf = 1'b0; m_mag = 0;
  endfunction

  function automatic void m_byte(byte unsigned b);
    longint unsigned two32 = 64'h1_0000_0000;
    if (b == 8'h0D) return;
    if (b >= 8'h30 && b <= 8'h39) begin
      if (!m_in_num) begin
        m_in_num = 1'b1; m_mag = 0; m_ovf = 1'b0;
      end
      m_mag = m_mag * 10 + longint'(b - 8'h30);
      if (m_mag >= two32) begin
        m_ovf = 1'b1;
        m_mag = m_mag % two32;
      end
      return;
    end
    if (m_in_num) begin
      m_push(m_neg ? 32'((two32 - m_mag) % two32) : 32'(m_mag), b == 8'h0A, 1'b0, m_ovf);
      m_in_num = 1'b0; m_mag = 0; m_ovf = 1'b0;
      m_neg = (b == 8'h2D);
      return;
    end
    m_neg = (b == 8'h2D);
    if (b == 8'h0A) m_push(32'd0, 1'b1, 1'b1, 1'b0);
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(byte unsigned b, bit wait_free);
    int sz;
    int t;
    sz = exp_q.size();
    m_byte(b);
    if (wait_free && exp_q.size() > sz) begin
      t = 0;
      while (out_valid && t < 200) begin
        cyc(1);
        t++;
      end
      check("wait_free", out_valid, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = b;
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic send_str(string s, bit wait_free);
    for (int i = 0; i < s.len(); i++) send(s[i], wait_free);
  endtask

  task automatic brk();
    m_clear();
    in_break = 1'b1;
    cyc(1);
    in_break = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      cyc(1);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_value"}, out_value, 0);
    check({tag, "_eol"}, out_eol, 0);
    check({tag, "_empty"}, out_empty, 0);
    check({tag, "_ovf"}, out_ovf, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Random consumer back-pressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare every accepted record against the scoreboard
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_record got value=%0h eol=%0b empty=%0b ovf=%0b want none",
                   out_value, out_eol, out_empty, out_ovf);
        end else begin
          r = exp_q.pop_front();
          if (out_value !== r.value || out_eol !== r.eol ||
              out_empty !== r.empty || out_ovf !== r.ovf) begin
            failures++;
            $display("FAIL record got value=%0h eol=%0b empty=%0b ovf=%0b want value=%0h eol=%0b empty=%0b ovf=%0b",
                     out_value, out_eol, out_empty, out_ovf, r.value, r.eol, r.empty, r.ovf);
          end
        end
      end
    end
  end

  initial begin
    int r;
    byte unsigned b;
    reset = 1'b1; in_valid = 1'b0; in_break = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    m_clear();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1);

    // 1: simple number with latency check
    send_str("123", 1'b1);
    send(8'h0A, 1'b1);
    check("t1_latency_valid", out_valid, 1'b1);
    check("t1_value", out_value, 123);
    drain();

    // 2: signed number, CR ignored
    send_str("7 -42", 1'b1);
    send(8'h0D, 1'b1);
    send(8'h0A, 1'b1);
    drain();

    // 3: blank lines and a dropped lone '-'
    send(8'h0A, 1'b1);
    send(8'h0A, 1'b1);
    send_str("5 x-", 1'b1);
    send(8'h0A, 1'b1);
    drain();

    // 4: overflow, then a clean token
    send_str("4294967296 1 ", 1'b1);
    drain();

    // 5: back-pressure, hold and overrun
    out_ready = 1'b0;
    cyc(1);
    send_str("1 ", 1'b0);
    check("t5_valid", out_valid, 1'b1);
    check("t5_value", out_value, 1);
    send_str("2 ", 1'b0);
    void'(exp_q.pop_back());
    check("t5_overrun", overrun, 1'b1);
    cyc(3);
    check("t5_hold_value", out_value, 1);
    check("t5_hold_valid", out_valid, 1'b1);
    check("t5_hold_eol", out_eol, 1'b0);
    out_ready = 1'b1;
    cyc(2);
    check("t5_valid_after_accept", out_valid, 1'b0);
    check("t5_overrun_sticky", overrun, 1'b1);
    drain();

    // 6a: break aborts the token in progress
    send_str("45", 1'b1);
    brk();
    send_str("6", 1'b1);
    send(8'h0A, 1'b1);
    drain();

    // 6b: reset aborts the token in progress and clears overrun
    send_str("12", 1'b1);
    reset = 1'b1;
    m_clear();
    #2;
    check_all_zero("t6_reset");
    cyc(1);
    reset = 1'b0;
    cyc(1);
    send_str("3", 1'b1);
    send(8'h0A, 1'b1);
    drain();

    // Randomised stream with random consumer stalls
    ready_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 93) begin
        if      (r < 50) b = 8'h30 + 8'($urandom_range(0, 9));
        else if (r < 60) b = 8'h20;
        else if (r < 68) b = 8'h2D;
        else if (r < 76) b = 8'h0A;
        else if (r < 82) b = 8'h0D;
        else if (r < 90) b = 8'h78;
        else             b = 8'h2C;
        send(b, 1'b1);
      end else if (r < 96) begin
        brk();
      end else begin
        for (int k = 0; k < 11; k++) send(8'h30 + 8'($urandom_range(0, 9)), 1'b1);
      end
      cyc($urandom_range(0, 2));
    end
    ready_rand = 1'b0;
    cyc(1);
    out_ready = 1'b1;
    drain();
    check("random_overrun", overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
